// File: rtl/mcast_arbiter.sv
// -----------------------------------------------------------------------------
// mcast_arbiter
//
// Purpose:
//   Multicast-capable output arbiter for a router with NPORT inputs and NPORT
//   outputs. Each input presents a head flit with a destination mask. The
//   arbiter grants heads all-or-nothing in the same cycle (no partial
//   delivery). Inputs are searched in round-robin order from rr_ptr. A
//   per-input age counter detects starvation. When an input has waited
//   STARVE_LIMIT cycles, a reservation is raised: that input is searched
//   first, and no other input may claim any output in its mask until the
//   starved input is served or withdraws.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   enable_mcast   1 = multi-destination heads may be granted
//   head_valid     input FIFO i has a head flit
//   head_dest      destination mask of head i at [i*NPORT +: NPORT]
//   out_ready      output o can accept a flit this cycle
//   fifo_pop       pop input FIFO i this cycle
//   out_valid      output o carries a flit this cycle
//   sel_in         source input for output o at [o*3 +: 3]
//   starve_active  reservation in force
//   starve_port    input holding the reservation
//   err_mcast_dis  sticky: multi-destination head seen while enable_mcast=0
//
// The 3-bit index fields limit NPORT to at most 8.
// -----------------------------------------------------------------------------
module mcast_arbiter #(
  parameter int NPORT        = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_mcast,
  input  logic [NPORT-1:0]     head_valid,
  input  logic [NPORT*NPORT-1:0] head_dest,
  input  logic [NPORT-1:0]     out_ready,
  output logic [NPORT-1:0]     fifo_pop,
  output logic [NPORT-1:0]     out_valid,
  output logic [3*NPORT-1:0]   sel_in,
  output logic                 starve_active,
  output logic [2:0]           starve_port,
  output logic                 err_mcast_dis
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, RESERVE = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      rr_ptr_reg;
  logic [2:0]      starve_port_reg;
  logic            err_reg;
  logic [3:0]      age_reg  [NPORT];
  logic [3:0]      age_next [NPORT];

  logic [NPORT-1:0] dest [NPORT];
  logic [NPORT-1:0] eligible;
  logic [NPORT-1:0] multi;

  logic [NPORT-1:0] grant;
  logic [NPORT-1:0] claimed;
  logic [NPORT-1:0] starve_dest;
  logic             first_found;
  logic [2:0]       first_idx;
  logic [2:0]       cand_idx;

  logic             hit_found;
  logic [2:0]       hit_idx;
  logic [2:0]       hit_cand;

  // (base + k) mod NPORT, with base < NPORT and k < NPORT.
  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    logic [3:0] s;
    s = {1'b0, base} + 4'(k);
    if (s >= 4'(NPORT)) s = s - 4'(NPORT);
    return s[2:0];
  endfunction

  // Per-input destination unpacking and eligibility.
  generate
    for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
      assign dest[gi]     = head_dest[gi*NPORT +: NPORT];
      assign multi[gi]    = ($countones(dest[gi]) > 1);
      // A nonzero, non-multi mask has exactly one bit set.
      assign eligible[gi] = head_valid[gi] && (dest[gi] != '0) &&
                            (enable_mcast || !multi[gi]);
    end
  endgenerate

  assign starve_dest = dest[starve_port_reg];

  // Grant search. A head is granted only if its whole mask is free and
  // ready, so partial delivery cannot happen. In RESERVE, the starved input
  // is searched first. The others may not touch any output in its mask.
  always_comb begin
    grant       = '0;
    claimed     = '0;
    first_found = 1'b0;
    first_idx   = '0;
    cand_idx    = '0;

    if (state_reg == RESERVE && eligible[starve_port_reg] &&
        (starve_dest & ~out_ready) == '0) begin
      grant[starve_port_reg] = 1'b1;
      claimed                = starve_dest;
      first_found            = 1'b1;
      first_idx              = starve_port_reg;
    end

    for (int k = 0; k < NPORT; k++) begin
      cand_idx = rr_idx(rr_ptr_reg, k);
      if (!(state_reg == RESERVE && cand_idx == starve_port_reg) &&
          eligible[cand_idx] &&
          (dest[cand_idx] & claimed) == '0 &&
          (dest[cand_idx] & ~out_ready) == '0 &&
          !(state_reg == RESERVE && (dest[cand_idx] & starve_dest) != '0)) begin
        grant[cand_idx] = 1'b1;
        claimed         = claimed | dest[cand_idx];
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = cand_idx;
        end
      end
    end
  end

  // Crossbar controls. Granted masks are disjoint, so each output has at
  // most one source.
  always_comb begin
    fifo_pop  = '0;
    out_valid = '0;
    sel_in    = '0;
    if (!rst) begin
      fifo_pop = grant;
      for (int o = 0; o < NPORT; o++) begin
        for (int i = 0; i < NPORT; i++) begin
          if (grant[i] && dest[i][o]) begin
            out_valid[o]       = 1'b1;
            sel_in[o*3 +: 3]   = 3'(i);
          end
        end
      end
    end
  end

  // Age counters: count blocked-while-eligible cycles, saturate at the limit.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      age_next[i] = '0;
      if (eligible[i] && !grant[i]) begin
        age_next[i] = (age_reg[i] >= LIMIT) ? LIMIT : age_reg[i] + 4'd1;
      end
    end
  end

  // The first saturated input in round-robin order wins the reservation.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    hit_cand  = '0;
    for (int k = 0; k < NPORT; k++) begin
      hit_cand = rr_idx(rr_ptr_reg, k);
      if (!hit_found && age_reg[hit_cand] == LIMIT) begin
        hit_found = 1'b1;
        hit_idx   = hit_cand;
      end
    end
  end

  // FSM: next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hit_found) state_next = RESERVE;
      RESERVE: if (grant[starve_port_reg] || !eligible[starve_port_reg])
                 state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: state register, plus pointer, reservation index, ages and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      starve_port_reg <= '0;
      err_reg         <= 1'b0;
      for (int i = 0; i < NPORT; i++) age_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && hit_found) starve_port_reg <= hit_idx;
      if (first_found) rr_ptr_reg <= rr_idx(first_idx, 1);
      err_reg <= err_reg | (|(head_valid & multi & {NPORT{~enable_mcast}}));
      for (int i = 0; i < NPORT; i++) age_reg[i] <= age_next[i];
    end
  end

  // FSM: outputs. These are forced to zero while reset is held.
  always_comb begin
    starve_active = !rst && (state_reg == RESERVE);
    starve_port   = rst ? 3'd0 : starve_port_reg;
    err_mcast_dis = !rst && err_reg;
  end

endmodule
